// File: rtl/seq_row_mul.sv
// Sequential N x N unsigned shift-add multiplier: one partial-product row per clock,
// start/done handshake, registered 2N-bit product held until the next completion.
module seq_row_mul #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int unsigned CW = $clog2(N);
    localparam int unsigned PW = 2 * N;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_last;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_acc_hi;
    logic [N-1:0]    r_acc_lo;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [PW-1:0]   r_p;

    logic [N-1:0]    w_t;
    logic [N:0]      w_c;
    logic [N:0]      w_z;

    // Row adder: multiplicand gated by the current multiplier bit, rippled into acc_hi.
    assign w_t    = r_a & {N{r_b[0]}};
    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign w_z[i]   = w_t[i] ^ r_acc_hi[i] ^ w_c[i];
        assign w_c[i+1] = (w_t[i] & r_acc_hi[i]) | (w_c[i] & (w_t[i] ^ r_acc_hi[i]));
    end

    assign w_z[N] = w_c[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status flags are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_acc_hi <= w_z[N:1];
            r_acc_lo <= {w_z[0], r_acc_lo[N-1:1]};
            r_b      <= r_b >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_p <= {w_z[N:1], w_z[0], r_acc_lo[N-1:1]};
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule

// File: doc/seq_row_mul.md
# seq_row_mul

Sequential N×N unsigned shift-add multiplier: one N-bit-by-1-bit partial-product row (multiplicand AND one multiplier bit, added to the running high accumulator with carry-out) is evaluated per clock. It sits upstream of the multiplier datapath as its sequencer, holding the accumulator and the multiplier shift register. It feeds the row one multiplier bit per cycle and delivers the registered 2N-bit product with a start/done handshake. The RTL contains its own row adder (AND gates plus ripple full-adder chain, carry-in tied 0); it does not instantiate external modules.

## Interface
- N, default 4, operand width (N ≥ 2).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  N  multiplicand, captured when start accepted.
- b  in  N  multiplier, captured when start accepted.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse, high exactly while in DONE.
- p  out  2N  product register; holds the last completed result.

## Operation
- States: IDLE, RUN, DONE. Counter cnt, width ceil(log2 N), counts RUN steps.
- IDLE with start=1: a_r←a, b_r←b, acc_hi←0, acc_lo←0, cnt←0, then → RUN. IDLE with start=0: stay.
- RUN step, one per edge:
  - t = a_r & {N{b_r[0]}}.
  - z[N:0] = t + acc_hi; carry-in 0, N+1-bit result, no overflow possible.
  - acc_hi ← z[N:1].
  - acc_lo ← {z[0], acc_lo[N-1:1]}.
  - b_r ← b_r >> 1.
  - cnt ← cnt+1.
- On the RUN edge with cnt = N-1: p ← {z[N:1], z[0], acc_lo[N-1:1]}, i.e. the post-step accumulator; then → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally.
- start is ignored in RUN and DONE. There is no queuing; the requester must hold or re-assert start.
- a and b changing after capture have no effect on an operation in flight.
- p changes only on the final RUN edge. It is held through IDLE and through subsequent RUN cycles until the next completion.
- Unsigned arithmetic throughout. The result is exact; max is (2^N−1)^2, which fits in 2N bits.
- Reset (asserted at any time, including mid-RUN): state=IDLE, busy=0, done=0, p=0, a_r=b_r=acc=cnt=0. The in-flight operation is aborted with no done pulse. On release, the first edge with rst_n=1 may accept start.

## Timing
- Edge E0: start sampled high in IDLE.
- Edges E1..EN: the N RUN steps; p is updated at EN.
- done=1 and busy=1 in the cycle after EN. IDLE is re-entered at EN+1.
- Start-to-done latency: done rises N edges after the accepting edge.
- Throughput with start held high: one result per N+2 cycles; the next start is accepted at edge EN+2.
- busy rises the cycle after acceptance and falls with done.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then N=4, a=15, b=15, start pulse: done after 4 edges, p=0xE1 (225); busy high for 5 cycles; done high for exactly 1.
- a=13, b=11 gives p=143 (0x8F). Then a=0, b=9 gives p=0. Then a=7, b=0 gives p=0. Check that p holds 143 until the second done.
- start held high continuously with a=3, b=5: a done pulse every 6 cycles, p=15 each time. Change a/b mid-RUN: the result uses the captured values.
- start pulsed during RUN and during DONE: ignored, no extra operation, and exactly one done per accepted start.
- rst_n low during RUN step 2 of a=9, b=9: p=0, busy=0, no done. After release, a=9, b=9 completes with p=81.
- Exhaustive sweep of all 256 (a,b) pairs at N=4, plus 1000 random pairs at N=8, checked against a behavioural a*b model.
